// File: rtl/axi_pkg.sv
// AXI4 field types shared by the channel structs and the responder.
// No ports: types only.
package axi_pkg;

  typedef logic [3:0]  id_t;
  typedef logic [63:0] addr_t;
  typedef logic [7:0]  len_t;
  typedef logic [2:0]  size_t;
  typedef logic [1:0]  burst_t;
  typedef logic [1:0]  resp_t;
  typedef logic [63:0] data_t;
  typedef logic [7:0]  strb_t;

endpackage

// File: rtl/sy_axi.sv
// AXI4 channel bundles of the core's 64-bit master port.
// req_t carries AW/W/AR plus b_ready/r_ready; resp_t carries the readies plus B/R.
package sy_axi;

  typedef struct packed {
    axi_pkg::id_t    id;
    axi_pkg::addr_t  addr;
    axi_pkg::len_t   len;
    axi_pkg::size_t  size;
    axi_pkg::burst_t burst;
  } ax_chan_t;

  typedef ax_chan_t aw_chan_t;
  typedef ax_chan_t ar_chan_t;

  typedef struct packed {
    axi_pkg::data_t data;
    axi_pkg::strb_t strb;
    logic           last;
  } w_chan_t;

  typedef struct packed {
    axi_pkg::id_t   id;
    axi_pkg::resp_t resp;
  } b_chan_t;

  typedef struct packed {
    axi_pkg::id_t   id;
    axi_pkg::data_t data;
    axi_pkg::resp_t resp;
    logic           last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

endpackage

// File: rtl/sy_axi_slv_pkg.sv
// Constants and FSM state type for the AXI SRAM responder.
// No ports.
package sy_axi_slv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdWait,
    StRdData,
    StWrData,
    StWrResp
  } slv_state_e;

  localparam axi_pkg::resp_t RESP_OKAY   = 2'b00;
  localparam axi_pkg::resp_t RESP_SLVERR = 2'b10;
  localparam axi_pkg::resp_t RESP_DECERR = 2'b11;

  localparam axi_pkg::burst_t BURST_FIXED = 2'b00;
  localparam axi_pkg::burst_t BURST_INCR  = 2'b01;
  localparam axi_pkg::burst_t BURST_WRAP  = 2'b10;

endpackage

// File: rtl/sy_axi_burst_addr.sv
// Combinational AXI burst address step.
// Ports:
//   addr_i      current byte address
//   len_i       burst length - 1
//   size_i      log2 of bytes per beat
//   burst_i     FIXED / INCR / WRAP
//   next_addr_o byte address of the following beat
//   bad_o       burst attributes are unsupported (size > 3, reserved type, bad wrap length)
module sy_axi_burst_addr
  import sy_axi_slv_pkg::*;
(
  input  axi_pkg::addr_t  addr_i,
  input  axi_pkg::len_t   len_i,
  input  axi_pkg::size_t  size_i,
  input  axi_pkg::burst_t burst_i,
  output axi_pkg::addr_t  next_addr_o,
  output logic            bad_o
);

  logic [63:0] step;
  logic [63:0] boundary;
  logic        wrap_len_ok;

  always_comb begin
    step        = 64'd1 << size_i;
    boundary    = ({56'd0, len_i} + 64'd1) << size_i;
    wrap_len_ok = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
    bad_o       = (size_i > 3'd3) || (burst_i == 2'b11) ||
                  ((burst_i == BURST_WRAP) && !wrap_len_ok);
    next_addr_o = addr_i;
    case (burst_i)
      BURST_INCR: next_addr_o = (addr_i & ~(step - 64'd1)) + step;
      // boundary is a power of two whenever the wrap length is legal
      BURST_WRAP: next_addr_o = (addr_i & ~(boundary - 64'd1)) +
                                ((addr_i + step) & (boundary - 64'd1));
      default:    next_addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/sy_axi_sram_slv.sv
// AXI4 responder in front of a single-port, 1-cycle-latency, 64-bit SRAM.
// One transaction at a time; reads and writes arbitrate round-robin in idle.
// Optional macro SY_AXI_SLV_RANGE_CHK_EN: start addresses outside
// [BaseAddr, BaseAddr + 8*2^MemAddrWidth) get DECERR and never touch the SRAM.
// Without it upper address bits are ignored and the region aliases.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   axi_req_i      AW/W/AR channels plus b_ready/r_ready
//   axi_resp_o     aw/w/ar readies plus B/R channels
//   mem_req_o      SRAM access strobe, mem_we_o 1 = write
//   mem_addr_o     SRAM word address
//   mem_wdata_o    write data, mem_be_o byte enables
//   mem_rdata_i    read data, valid the cycle after a read strobe
module sy_axi_sram_slv #(
  parameter int unsigned MemAddrWidth = 14,
  parameter logic [63:0] BaseAddr     = 64'h8000_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  sy_axi::req_t            axi_req_i,
  output sy_axi::resp_t           axi_resp_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [MemAddrWidth-1:0] mem_addr_o,
  output logic [63:0]             mem_wdata_o,
  output logic [7:0]              mem_be_o,
  input  logic [63:0]             mem_rdata_i
);

  import sy_axi_slv_pkg::*;

  slv_state_e st_q, st_d;

  logic            rdy_en_q;  // keeps the readies low until the first cycle out of reset
  logic            prio_q;    // 1: last grant went to the write channel
  axi_pkg::id_t    id_q;
  axi_pkg::addr_t  addr_q;
  axi_pkg::len_t   len_q, beat_q;
  axi_pkg::size_t  size_q;
  axi_pkg::burst_t burst_q;
  axi_pkg::resp_t  err_q;
  logic            last_err_q;
  axi_pkg::data_t  rdata_q;

  logic            grant_w, grant_r, aw_hs, ar_hs, w_hs, r_hs, b_hs, beat_last;
  axi_pkg::addr_t  ba_addr, next_addr;
  axi_pkg::len_t   ba_len;
  axi_pkg::size_t  ba_size;
  axi_pkg::burst_t ba_burst;
  logic            ba_bad, out_of_range;
  axi_pkg::resp_t  grant_err;

  assign grant_w   = axi_req_i.aw_valid && (!axi_req_i.ar_valid || !prio_q);
  assign grant_r   = axi_req_i.ar_valid && !grant_w;
  assign aw_hs     = rdy_en_q && (st_q == StIdle) && grant_w;
  assign ar_hs     = rdy_en_q && (st_q == StIdle) && grant_r;
  assign w_hs      = (st_q == StWrData) && axi_req_i.w_valid;
  assign r_hs      = (st_q == StRdData) && axi_req_i.r_ready;
  assign b_hs      = (st_q == StWrResp) && axi_req_i.b_ready;
  assign beat_last = (beat_q == len_q);

  // In idle the address unit checks the channel about to be granted; otherwise it steps the burst.
  always_comb begin
    ba_addr  = addr_q;
    ba_len   = len_q;
    ba_size  = size_q;
    ba_burst = burst_q;
    if (st_q == StIdle) begin
      if (grant_w) begin
        ba_addr  = axi_req_i.aw.addr;
        ba_len   = axi_req_i.aw.len;
        ba_size  = axi_req_i.aw.size;
        ba_burst = axi_req_i.aw.burst;
      end else begin
        ba_addr  = axi_req_i.ar.addr;
        ba_len   = axi_req_i.ar.len;
        ba_size  = axi_req_i.ar.size;
        ba_burst = axi_req_i.ar.burst;
      end
    end
  end

  sy_axi_burst_addr u_burst_addr (
    .addr_i      (ba_addr),
    .len_i       (ba_len),
    .size_i      (ba_size),
    .burst_i     (ba_burst),
    .next_addr_o (next_addr),
    .bad_o       (ba_bad)
  );

`ifdef SY_AXI_SLV_RANGE_CHK_EN
  localparam logic [63:0] RegionEnd = BaseAddr + (64'd8 << MemAddrWidth);
  assign out_of_range = (ba_addr < BaseAddr) || (ba_addr >= RegionEnd);
`else
  logic unused_base;
  assign unused_base  = ^BaseAddr;
  assign out_of_range = 1'b0;
`endif

  assign grant_err = out_of_range ? RESP_DECERR : (ba_bad ? RESP_SLVERR : RESP_OKAY);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_q <= StIdle;
    end else begin
      st_q <= st_d;
    end
  end

  // Next-state logic
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      StIdle: begin
        if (aw_hs) begin
          st_d = StWrData;
        end else if (ar_hs) begin
          st_d = StRdIssue;
        end
      end
      StRdIssue: st_d = StRdWait;
      StRdWait:  st_d = StRdData;
      StRdData:  if (r_hs) st_d = beat_last ? StIdle : StRdIssue;
      StWrData:  if (w_hs && beat_last) st_d = StWrResp;
      StWrResp:  if (b_hs) st_d = StIdle;
      default:   st_d = StIdle;
    endcase
  end

  // Transaction context and beat bookkeeping
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdy_en_q   <= 1'b0;
      prio_q     <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      err_q      <= RESP_OKAY;
      last_err_q <= 1'b0;
      beat_q     <= '0;
      rdata_q    <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      if (aw_hs || ar_hs) begin
        prio_q     <= aw_hs;
        id_q       <= aw_hs ? axi_req_i.aw.id : axi_req_i.ar.id;
        addr_q     <= ba_addr;
        len_q      <= ba_len;
        size_q     <= ba_size;
        burst_q    <= ba_burst;
        err_q      <= grant_err;
        last_err_q <= 1'b0;
        beat_q     <= '0;
        rdata_q    <= '0;
      end
      if (st_q == StRdWait) begin
        rdata_q <= (err_q == RESP_OKAY) ? mem_rdata_i : '0;
      end
      if (r_hs && !beat_last) begin
        addr_q <= next_addr;
        beat_q <= beat_q + 8'd1;
      end
      if (w_hs) begin
        if (axi_req_i.w.last != beat_last) begin
          last_err_q <= 1'b1;
        end
        if (!beat_last) begin
          addr_q <= next_addr;
          beat_q <= beat_q + 8'd1;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    axi_resp_o  = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    unique case (st_q)
      StIdle: begin
        axi_resp_o.aw_ready = rdy_en_q && grant_w;
        axi_resp_o.ar_ready = rdy_en_q && grant_r;
      end
      StRdIssue: begin
        mem_req_o  = (err_q == RESP_OKAY);
        mem_addr_o = addr_q[MemAddrWidth+2:3];
      end
      StRdData: begin
        axi_resp_o.r_valid = 1'b1;
        axi_resp_o.r.id    = id_q;
        axi_resp_o.r.data  = rdata_q;
        axi_resp_o.r.resp  = err_q;
        axi_resp_o.r.last  = beat_last;
      end
      StWrData: begin
        axi_resp_o.w_ready = 1'b1;
        // Write strobe follows the W handshake in the same cycle.
        if (axi_req_i.w_valid && (err_q == RESP_OKAY)) begin
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = addr_q[MemAddrWidth+2:3];
          mem_wdata_o = axi_req_i.w.data;
          mem_be_o    = axi_req_i.w.strb;
        end
      end
      StWrResp: begin
        axi_resp_o.b_valid = 1'b1;
        axi_resp_o.b.id    = id_q;
        axi_resp_o.b.resp  = (err_q != RESP_OKAY) ? err_q :
                             (last_err_q ? RESP_SLVERR : RESP_OKAY);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sy_axi_sram_slv.sv
module tb_sy_axi_sram_slv;

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  logic          clk = 1'b0;
  logic          rst_n;
  sy_axi::req_t  req;
  sy_axi::resp_t rsp;
  logic          mem_req, mem_we;
  logic [13:0]   mem_addr;
  logic [63:0]   mem_wdata, mem_rdata;
  logic [7:0]    mem_be;

  always #5 clk = ~clk;

  sy_axi_sram_slv dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .axi_req_i   (req),
    .axi_resp_o  (rsp),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_rdata_i (mem_rdata)
  );

  // SRAM stand-in plus access log
  logic [63:0] sram [0:16383];
  logic [13:0] mon_addr[$];
  logic        mon_we[$];

  always @(posedge clk) begin
    if (mem_req) begin
      mon_addr.push_back(mem_addr);
      mon_we.push_back(mem_we);
      if (mem_we) begin
        for (int k = 0; k < 8; k++) if (mem_be[k]) sram[mem_addr][k*8 +: 8] <= mem_wdata[k*8 +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int ch);
    case (ch)
      0: return rsp.aw_ready;
      1: return rsp.w_ready;
      2: return rsp.b_valid;
      3: return rsp.ar_ready;
      default: return rsp.r_valid;
    endcase
  endfunction

  // Waits at negedges for a handshake signal; cyc = negedges waited (0 on timeout).
  task automatic wait_hi(input int ch, output int cyc);
    cyc = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (sig(ch)) begin
        cyc = n;
        break;
      end
    end
    if (cyc == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL wait_ch%0d: still low after 40 cycles, required high", ch);
    end
  endtask

  typedef struct {
    bit               wr;
    logic [3:0]       id;
    logic [63:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [1:0]       resp;
    int               nreq;
    logic [3:0][13:0] maddr;
    logic [3:0][63:0] data;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [3:0] id, logic [63:0] addr, logic [7:0] len,
                              logic [2:0] size, logic [1:0] burst, logic [1:0] resp, int nreq,
                              logic [13:0] m0, logic [13:0] m1, logic [13:0] m2, logic [13:0] m3,
                              logic [63:0] d0, logic [63:0] d1, logic [63:0] d2,
                              logic [63:0] d3);
    vec_t v;
    v.wr = wr; v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.resp = resp; v.nreq = nreq;
    v.maddr[0] = m0; v.maddr[1] = m1; v.maddr[2] = m2; v.maddr[3] = m3;
    v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
    return v;
  endfunction

  task automatic do_write(input vec_t v, input int last_beat);
    int cyc;
    req.aw = '{id: v.id, addr: v.addr, len: v.len, size: v.size, burst: v.burst};
    req.aw_valid = 1'b1;
    wait_hi(0, cyc);
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
    for (int b = 0; b <= int'(v.len); b++) begin
      req.w = '{data: v.data[b], strb: 8'hFF, last: (b == last_beat)};
      req.w_valid = 1'b1;
      wait_hi(1, cyc);
      @(posedge clk); #1;
    end
    req.w_valid = 1'b0;
    req.b_ready = 1'b1;
    wait_hi(2, cyc);
    chk("b_resp", rsp.b.resp, v.resp);
    chk("b_id", rsp.b.id, v.id);
    @(posedge clk); #1;
    req.b_ready = 1'b0;
  endtask

  task automatic do_read(input vec_t v);
    int cyc;
    req.ar = '{id: v.id, addr: v.addr, len: v.len, size: v.size, burst: v.burst};
    req.ar_valid = 1'b1;
    req.r_ready  = 1'b1;
    wait_hi(3, cyc);
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    for (int b = 0; b <= int'(v.len); b++) begin
      wait_hi(4, cyc);
      chk("r_latency", cyc, 3);
      chk("r_data", rsp.r.data, v.data[b]);
      chk("r_resp", rsp.r.resp, v.resp);
      chk("r_id", rsp.r.id, v.id);
      chk("r_last", rsp.r.last, b == int'(v.len));
      @(posedge clk); #1;
    end
    req.r_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int last_beat);
    mon_addr.delete();
    mon_we.delete();
    if (v.wr) do_write(v, last_beat);
    else      do_read(v);
    chk("mem_req_count", mon_addr.size(), v.nreq);
    for (int i = 0; i < v.nreq && i < mon_addr.size(); i++) begin
      chk("mem_addr", mon_addr[i], v.maddr[i]);
      chk("mem_we", mon_we[i], v.wr);
    end
  endtask

  vec_t vecs[$];

  initial begin
    int cyc;
    vec_t v;

    for (int i = 0; i < 16384; i++) sram[i] = '0;
    mem_rdata = '0;
    req   = '0;
    rst_n = 1'b0;

    // Reset, with both address channels already requesting
    req.aw = '{id: 4'd9, addr: 64'h8000_0100, len: 8'd0, size: 3'd3, burst: INCR};
    req.ar = '{id: 4'd10, addr: 64'h8000_0100, len: 8'd0, size: 3'd3, burst: INCR};
    req.aw_valid = 1'b1;
    req.ar_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_resp_zero", |rsp, 1'b0);
    chk("reset_mem_req", mem_req, 1'b0);
    chk("reset_mem_we", mem_we, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_aw_ready_c0", rsp.aw_ready, 1'b0);
    @(negedge clk);
    chk("arb_aw_first", rsp.aw_ready, 1'b1);
    chk("arb_ar_blocked", rsp.ar_ready, 1'b0);
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
    req.w = '{data: 64'h55, strb: 8'hFF, last: 1'b1};
    req.w_valid = 1'b1;
    @(negedge clk);
    chk("arb_ar_busy", rsp.ar_ready, 1'b0);
    @(posedge clk); #1;
    req.w_valid = 1'b0;
    req.b_ready = 1'b1;
    wait_hi(2, cyc);
    chk("arb_b_resp", rsp.b.resp, OKAY);
    chk("arb_b_id", rsp.b.id, 9);
    @(posedge clk); #1;
    req.b_ready = 1'b0;
    @(negedge clk);
    chk("arb_ar_next", rsp.ar_ready, 1'b1);
    req.ar_valid = 1'b0;
    do_read(mk(0, 10, 64'h8000_0100, 0, 3, INCR, OKAY, 1, 14'h20, 0, 0, 0, 64'h55, 0, 0, 0));

    // Directed vectors
    vecs.push_back(mk(1, 3, 64'h8000_0010, 0, 3, INCR, OKAY, 1, 2, 0, 0, 0,
                      64'hDEADBEEF_CAFEF00D, 0, 0, 0));
    vecs.push_back(mk(0, 5, 64'h8000_0010, 0, 3, INCR, OKAY, 1, 2, 0, 0, 0,
                      64'hDEADBEEF_CAFEF00D, 0, 0, 0));
    vecs.push_back(mk(1, 1, 64'h8000_0000, 3, 3, INCR, OKAY, 4, 0, 1, 2, 3, 1, 2, 3, 4));
    vecs.push_back(mk(0, 2, 64'h8000_0000, 3, 3, INCR, OKAY, 4, 0, 1, 2, 3, 1, 2, 3, 4));
    vecs.push_back(mk(0, 6, 64'h8000_0018, 3, 3, WRAP, OKAY, 4, 3, 0, 1, 2, 4, 1, 2, 3));
    vecs.push_back(mk(0, 7, 64'h8000_0000, 0, 4, INCR, SLVERR, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4, 64'h8000_0020, 0, 3, 2'b11, SLVERR, 0, 0, 0, 0, 0, 64'h99, 0, 0, 0));
    vecs.push_back(mk(0, 8, 64'h8000_0020, 0, 3, INCR, OKAY, 1, 4, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 9, 64'h8000_0008, 2, 3, FIXED, OKAY, 3, 1, 1, 1, 0, 2, 2, 2, 0));
    vecs.push_back(mk(0, 10, 64'h8000_0000, 2, 3, WRAP, SLVERR, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef SY_AXI_SLV_RANGE_CHK_EN
    vecs.push_back(mk(0, 11, 64'h0, 0, 3, INCR, DECERR, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`else
    vecs.push_back(mk(0, 11, 64'h0, 0, 3, INCR, OKAY, 1, 0, 0, 0, 0, 1, 0, 0, 0));
`endif
    vecs.push_back(mk(1, 12, 64'h8001_FFF8, 1, 3, INCR, OKAY, 2, 14'h3FFF, 0, 0, 0,
                      64'hA, 64'hB, 0, 0));
    vecs.push_back(mk(0, 13, 64'h8000_0000, 0, 3, INCR, OKAY, 1, 0, 0, 0, 0, 64'hB, 0, 0, 0));
    vecs.push_back(mk(0, 14, 64'h8001_FFF8, 1, 3, INCR, OKAY, 2, 14'h3FFF, 0, 0, 0,
                      64'hA, 64'hB, 0, 0));
    foreach (vecs[i]) run_vec(vecs[i], int'(vecs[i].len));

    // w.last on beat 0 of a two-beat write: both beats land, B is SLVERR
    run_vec(mk(1, 14, 64'h8000_0040, 1, 3, INCR, SLVERR, 2, 8, 9, 0, 0, 64'h11, 64'h22, 0, 0), 0);
    run_vec(mk(0, 1, 64'h8000_0040, 1, 3, INCR, OKAY, 2, 8, 9, 0, 0, 64'h11, 64'h22, 0, 0), 1);

    // R backpressure: fields hold while r_ready is low
    req.ar = '{id: 4'd13, addr: 64'h8000_0000, len: 8'd1, size: 3'd3, burst: INCR};
    req.ar_valid = 1'b1;
    wait_hi(3, cyc);
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    wait_hi(4, cyc);
    chk("bp_latency", cyc, 3);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_r_valid", rsp.r_valid, 1'b1);
      chk("bp_r_data", rsp.r.data, 64'hB);
      chk("bp_r_id", rsp.r.id, 13);
      chk("bp_r_last", rsp.r.last, 1'b0);
    end
    req.r_ready = 1'b1;
    @(posedge clk); #1;
    wait_hi(4, cyc);
    chk("bp_beat1_latency", cyc, 3);
    chk("bp_beat1_data", rsp.r.data, 64'h2);
    chk("bp_beat1_last", rsp.r.last, 1'b1);
    @(posedge clk); #1;
    req.r_ready = 1'b0;

    // Reset during beat 2 of a len-7 read, with r_ready high
    req.ar = '{id: 4'd11, addr: 64'h8000_0000, len: 8'd7, size: 3'd3, burst: INCR};
    req.ar_valid = 1'b1;
    req.r_ready  = 1'b1;
    wait_hi(3, cyc);
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wait_hi(4, cyc);
      @(posedge clk); #1;
    end
    wait_hi(4, cyc);
    chk("mid_beat2_data", rsp.r.data, 64'h3);
    rst_n = 1'b0;
    req.ar = '{id: 4'd12, addr: 64'h8000_0008, len: 8'd0, size: 3'd3, burst: INCR};
    req.ar_valid = 1'b1;
    @(negedge clk);
    chk("mid_rst_resp_zero", |rsp, 1'b0);
    chk("mid_rst_mem_req", mem_req, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_ar_ready_c0", rsp.ar_ready, 1'b0);
    chk("mid_rel_r_valid", rsp.r_valid, 1'b0);
    @(negedge clk);
    chk("mid_rel_ar_ready_c1", rsp.ar_ready, 1'b1);
    req.ar_valid = 1'b0;
    do_read(mk(0, 12, 64'h8000_0008, 0, 3, INCR, OKAY, 1, 1, 0, 0, 0, 64'h2, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
